// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 1-cycle-latency dual-port RAM, with a FWFT output through a 2-entry prefetch buffer.
// Latency: 3 cycles from push to out_valid. Backpressure: in_ready drops when the RAM is full; out_ready=0 stalls prefetch reads.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_rea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam logic [ADDR_WIDTH:0] RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_INC  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            pf_cnt_q, pf_cnt_d;
    logic                  pf_head_q, pf_head_d;
    logic                  pf_tail_q, pf_tail_d;
    logic [DATA_WIDTH-1:0] pf_dat_q [2];

    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [2:0]            pf_after;
    logic                  push;
    logic                  pop;

    assign ram_cnt   = wr_ptr_q - rd_ptr_q;
    assign in_ready  = rstn & (ram_cnt != RAM_FULL);
    assign push      = in_valid & in_ready & ~clr;
    assign out_valid = (pf_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;

    // Buffer occupancy once this cycle's pop and the in-flight return have settled.
    assign pf_after  = 3'(pf_cnt_q) + 3'(rd_pend_q) - 3'(pop);
    assign ram_rea   = ~clr & (ram_cnt != '0) & (pf_after < 3'd2);

    assign ram_wea   = push;
    assign ram_addra = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_dina  = in_data;
    assign ram_addrb = rd_ptr_q[ADDR_WIDTH-1:0];

    assign out_data  = pf_dat_q[pf_head_q];
    assign count     = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(rd_pend_q)
                     + (ADDR_WIDTH+2)'(pf_cnt_q);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_pend_d = rd_pend_q;
        pf_cnt_d  = pf_cnt_q;
        pf_head_d = pf_head_q;
        pf_tail_d = pf_tail_q;
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rd_pend_d = 1'b0;
            pf_cnt_d  = 2'd0;
            pf_head_d = 1'b0;
            pf_tail_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_INC;
            end
            if (ram_rea) begin
                rd_ptr_d = rd_ptr_q + PTR_INC;
            end
            rd_pend_d = ram_rea;
            if (rd_pend_q) begin
                pf_tail_d = ~pf_tail_q;
            end
            if (pop) begin
                pf_head_d = ~pf_head_q;
            end
            pf_cnt_d = pf_cnt_q + 2'(rd_pend_q) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            pf_cnt_q  <= 2'd0;
            pf_head_q <= 1'b0;
            pf_tail_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            pf_cnt_q  <= pf_cnt_d;
            pf_head_q <= pf_head_d;
            pf_tail_q <= pf_tail_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by pf_cnt_q alone.
    always_ff @(posedge clk) begin
        if (rd_pend_q && !clr) begin
            pf_dat_q[pf_tail_q] <= ram_doutb;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, stage-queue reference model checked every cycle, directed and random stimulus.
module tb_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          ram_rea;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_rea(ram_rea), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // Dual-port RAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_rea) ram_doutb <= mem[ram_addrb];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    endtask

    // Reference model: words move RAM -> read in flight -> prefetch buffer -> consumer.
    logic [DW-1:0] m_ram[$];
    logic [DW-1:0] m_infl[$];
    logic [DW-1:0] m_buf[$];
    logic [DW-1:0] sb[$];
    int            m_pushes = 0;

    always @(negedge clk) begin : cmp
        bit m_rdy;
        bit m_push;
        bit m_pop;
        bit m_issue;
        if (!rstn) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_count", count, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_ram_rea", ram_rea, 0);
            check("rst_ram_wea", ram_wea, 0);
            m_ram.delete(); m_infl.delete(); m_buf.delete(); sb.delete();
        end else begin
            m_rdy   = (m_ram.size() != DEPTH);
            m_pop   = (m_buf.size() != 0) && out_ready;
            m_issue = !clr && (m_ram.size() != 0)
                      && (m_buf.size() + m_infl.size() - int'(m_pop) < 2);
            m_push  = in_valid && m_rdy && !clr;
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_buf.size() != 0);
            if (m_buf.size() != 0) check("out_data", out_data, m_buf[0]);
            check("count", count, m_ram.size() + m_infl.size() + m_buf.size());
            check("ram_rea", ram_rea, m_issue);
            check("ram_wea", ram_wea, m_push);
            if (clr) begin
                m_ram.delete(); m_infl.delete(); m_buf.delete(); sb.delete();
            end else begin
                if (m_pop) begin
                    if (sb.size() != 0) check("sb_order", out_data, sb.pop_front());
                    void'(m_buf.pop_front());
                end
                if (m_infl.size() != 0) m_buf.push_back(m_infl.pop_front());
                if (m_issue) m_infl.push_back(m_ram.pop_front());
                if (m_push) begin
                    m_ram.push_back(in_data);
                    sb.push_back(in_data);
                    m_pushes++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_expect(input string nm, input logic [DW-1:0] d);
        int lat;
        lat = -1;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && lat < 0) begin
                lat = c;
                check({nm, "_data"}, out_data, d);
            end
            cyc();
            in_valid = 1'b0;
        end
        check({nm, "_latency"}, lat, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] got[$];
        int accepted, first, last, nvalid, idx, start;

        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        check("reset_count_async", count, 0);
        check("reset_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_count", count, 0);

        // Single word latency.
        cyc(); in_valid = 1'b1; in_data = 32'hA1; out_ready = 1'b1;
        @(negedge clk); check("t1_c0_wea", ram_wea, 1); check("t1_c0_addra", ram_addra, 0);
        cyc(); in_valid = 1'b0;
        @(negedge clk); check("t1_c1_rea", ram_rea, 1); check("t1_c1_addrb", ram_addrb, 0);
        check("t1_c1_count", count, 1);
        cyc();
        @(negedge clk); check("t1_c2_count", count, 1); check("t1_c2_valid", out_valid, 0);
        cyc();
        @(negedge clk); check("t1_c3_valid", out_valid, 1); check("t1_c3_data", out_data, 32'hA1);
        check("t1_c3_count", count, 1);
        cyc();
        @(negedge clk); check("t1_c4_count", count, 0); check("t1_c4_valid", out_valid, 0);

        // Fill to capacity with the consumer stalled, then drain.
        cyc(); out_ready = 1'b0;
        accepted = 0;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = k;
            @(negedge clk);
            if (in_ready) accepted++;
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_accepted", accepted, 6);
        check("t2_count_full", count, 6);
        check("t2_in_ready_full", in_ready, 0);
        cyc(); out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) check("t2_ready_first_pop", in_ready, 0);
            if (c == 1) check("t2_ready_after_read", in_ready, 1);
            if (out_valid) got.push_back(out_data);
            cyc();
        end
        check("t2_drained", got.size(), 6);
        for (int i = 0; i < got.size(); i++) check("t2_order", got[i], i + 1);

        // Streaming without bubbles across pointer wrap.
        first = -1; last = -1; nvalid = 0; idx = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c < 20); in_data = c;
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                nvalid++;
                check("t3_data", out_data, idx);
                idx++;
            end
            cyc();
        end
        in_valid = 1'b0;
        check("t3_first_valid", first, 3);
        check("t3_valid_cycles", nvalid, 20);
        check("t3_no_bubbles", last - first, 19);

        // Random traffic with occasional flushes.
        start = m_pushes;
        for (int c = 0; c < 20000 && (m_pushes - start) < 1000; c++) begin
            in_valid  = $urandom_range(1, 0);
            out_ready = $urandom_range(1, 0);
            clr       = ($urandom_range(96, 0) == 0);
            in_data   = $urandom;
            @(negedge clk);
            cyc();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("t4_words_done", (m_pushes - start) >= 1000, 1);
        for (int c = 0; c < 50 && count != 0; c++) cyc();
        check("t4_drain_count", count, 0);

        // Flush with a simultaneous push and pop.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h50 + k;
            cyc();
        end
        in_valid = 1'b1; in_data = 32'hEE; out_ready = 1'b1; clr = 1'b1;
        @(negedge clk); check("t5_clr_wea", ram_wea, 0); check("t5_clr_rea", ram_rea, 0);
        cyc(); clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_count", count, 0); check("t5_valid", out_valid, 0); check("t5_in_ready", in_ready, 1);
        cyc();
        push_and_expect("t5_after_clr", 32'h55);

        // Asynchronous reset with words held.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 32'h61 + k;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk); check("t6_count_held", count, 4); check("t6_valid_held", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("t6_rea_before_reset", ram_rea, 1);
        #1 rstn = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_rea", ram_rea, 0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        push_and_expect("t6_after_reset", 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Single-clock FIFO controller placed directly upstream of the NoP dual-port block RAM (DATA_WIDTH x 2^ADDR_WIDTH, registered read, 1-cycle read latency).
- Accepts a valid/ready write stream and drives the RAM's write and read ports.
- Hides the RAM read latency behind a 2-entry prefetch buffer, presenting a first-word-fall-through valid/ready output stream that sustains 1 word/cycle.

Parameters:
DATA_WIDTH, 32, payload width; must match the RAM.
ADDR_WIDTH, 4, RAM address width; RAM depth = 2^ADDR_WIDTH; total capacity = 2^ADDR_WIDTH + 2.

Ports:
clk  in  1  single clock; also drives the RAM's clka and clkb.
rstn  in  1  asynchronous active-low reset.
clr  in  1  synchronous flush, active-high.
in_valid  in  1  write request.
in_ready  out  1  write accept.
in_data  in  DATA_WIDTH  write payload.
out_valid  out  1  head word valid.
out_ready  in  1  consumer accepts head.
out_data  out  DATA_WIDTH  head word.
count  out  ADDR_WIDTH+2  total occupancy (RAM + in-flight read + buffer).
ram_wea  out  1  to RAM wea.
ram_addra  out  ADDR_WIDTH  to RAM addra.
ram_dina  out  DATA_WIDTH  to RAM dina.
ram_rea  out  1  to RAM rea.
ram_addrb  out  ADDR_WIDTH  to RAM addrb.
ram_doutb  in  DATA_WIDTH  from RAM doutb.

Behaviour:
- Clock and reset: one clock (clk). Reset rstn is asynchronous, active-low.
- State:
  - wr_ptr, rd_ptr: ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
  - ram_cnt = wr_ptr - rd_ptr.
  - rd_pend: 1 bit.
  - Prefetch buffer: 2 entries, buf_cnt in 0..2, head/tail index.
- Reset (rstn low, async): pointers, rd_pend and buf_cnt = 0. out_valid = 0, in_ready = 0 while in reset, count = 0, ram_wea = 0, ram_rea = 0. out_data is don't-care.
- Write side:
  - in_ready = (ram_cnt != 2^ADDR_WIDTH), from registered state only.
  - push = in_valid & in_ready.
  - Combinational: ram_wea = push, ram_addra = wr_ptr[ADDR_WIDTH-1:0], ram_dina = in_data.
  - wr_ptr increments on push; the address wraps modulo 2^ADDR_WIDTH and the wrap bit toggles.
- Read issue (combinational):
  - pop = out_valid & out_ready.
  - ram_rea = (ram_cnt != 0) & (buf_cnt + rd_pend - pop < 2).
  - ram_addrb = rd_ptr[ADDR_WIDTH-1:0]; rd_ptr increments when ram_rea is high.
  - ram_cnt uses registered pointers, so a word written in cycle t is readable no earlier than cycle t+1. This avoids same-address read/write collision in the RAM.
- Read return:
  - rd_pend <= ram_rea.
  - When rd_pend = 1, ram_doutb is written into the buffer tail at that clock edge.
- Output:
  - out_valid = (buf_cnt != 0); out_data = buffer head (registered).
  - On pop the head advances.
  - Simultaneous fill and pop keeps buf_cnt unchanged.
- Latency and throughput:
  - Push accepted in cycle 0 into an empty FIFO -> ram_rea in cycle 1 -> buffer loaded at end of cycle 2 -> out_valid = 1 in cycle 3.
  - Steady state: 1 push and 1 pop per cycle with no bubbles.
- count = ram_cnt + rd_pend + buf_cnt, registered-state based. count never exceeds 2^ADDR_WIDTH + 2.
- Full: in_ready = 0 when the RAM holds 2^ADDR_WIDTH words, regardless of a same-cycle pop. Space freed by a pop appears in in_ready no earlier than the next cycle.
- Empty: out_valid = 0; out_ready is ignored; ram_rea = 0.
- clr (synchronous, highest priority over push and pop):
  - All pointers, rd_pend and buf_cnt return to 0; the cycle's push and pop are discarded.
  - ram_rea = 0 and ram_wea = 0 in the clr cycle.
  - A read return landing in the cycle after clr is dropped, because rd_pend was cleared.
- Reset mid-operation: all state is discarded immediately and async; RAM contents are not cleared and are never read back, since pointers restart at 0.
- Data ordering is strict FIFO; no word is duplicated or lost, including across pointer wrap.

Test Plan:
1. ADDR_WIDTH=2. Reset, then push 0xA1 with out_ready=1 -> ram_wea=1 and ram_addra=0 in cycle 0; ram_rea=1 and ram_addrb=0 in cycle 1; out_valid=1 with out_data=0xA1 in cycle 3; count reads 1 from cycle 1 until the pop.
2. out_ready=0, push 0x01..0x08 continuously -> 6 words accepted (4 RAM + 2 buffer), in_ready=0 afterwards, count=6. Then out_ready=1 -> output 0x01..0x06 in order; in_ready rises the cycle after the first RAM read frees a slot.
3. Streaming: 20 consecutive words 0x00..0x13, in_valid=1 and out_ready=1 throughout -> after the 3-cycle fill, out_valid is high 20 consecutive cycles, data in order, pointers wrapped 5 times, no bubbles.
4. Random in_valid and out_ready (50%), 1000 words -> scoreboard matches exactly; count always equals the model; no push while in_ready=0 is accepted.
5. Load 5 words, then assert clr in the same cycle as a push and a pop -> next cycle count=0, out_valid=0, in_ready=1. Then push 0x55 -> the output is 0x55, with no stale data.
6. Assert rstn low asynchronously mid-stream with 4 words held -> out_valid, count and ram_rea go to 0 without a clock edge. After release, a new word 0x77 emerges first, 3 cycles after its push.
